alu_seq: RTL



---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_seq_shifter.sv | 51 +++++
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag bit indices and FSM states for alu_seq (S_MUL only with ALU_SEQ_MUL_EN)
package alu_seq_pkg;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;
    localparam logic [7:0] OP_MUL  = 8'h8E;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef ALU_SEQ_MUL_EN
        , S_MUL
`endif
    } state_t;
endpackage

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: iterative one-bit-per-cycle shifter; signed b picks direction, magnitude clamped to WIDTH
module alu_seq_shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             arith,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             zero,
    output logic             last,
    output logic [WIDTH-1:0] next
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   bx, mag;
    logic [CW-1:0]    amt, cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             right_q, right_d, arith_q, arith_d;

    // negation at WIDTH+1 bits keeps the most-negative amount positive before clamping
    always_comb begin
        bx      = {b[WIDTH-1], b};
        mag     = b[WIDTH-1] ? -bx : bx;
        amt     = (mag > (WIDTH+1)'(WIDTH)) ? CW'(WIDTH) : mag[CW-1:0];
        next    = right_q ? {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};
        data_d  = load ? a : step ? next : data_q;
        cnt_d   = load ? amt : step ? cnt_q - CW'(1) : cnt_q;
        right_d = load ? b[WIDTH-1] : right_q;
        arith_d = load ? arith : arith_q;
    end

    assign zero = amt == '0;
    assign last = cnt_q == CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            arith_q <= arith_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with persistent flags, iterative shifts and optional iterative MUL (ALU_SEQ_MUL_EN)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_wb,
    output logic             out_illegal,
    output logic [4:0]       flags
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             wb_q, wb_d, ill_q, ill_d, ov_q, ov_d;
    logic [4:0]       flg_q, flg_d;
    logic [WIDTH:0]   sum, diff;
    logic             ovf_add, ovf_sub, accept, upd_z;
    logic             sh_load, sh_step, sh_zero, sh_last;
    logic [WIDTH-1:0] sh_next;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_nx;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]      mcnt_q, mcnt_d;
`endif

    assign in_ready = (state_q == S_IDLE) && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;

    alu_seq_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .step  (sh_step),
        .arith (op == OP_ASHU),
        .a     (a),
        .b     (b),
        .zero  (sh_zero),
        .last  (sh_last),
        .next  (sh_next)
    );

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) & flg_q[FLAG_C]};
        diff    = {1'b0, b} - {1'b0, a};
        ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
        state_d = state_q;
        res_d   = res_q;
        wb_d    = wb_q;
        ill_d   = ill_q;
        flg_d   = flg_q;
        ov_d    = ov_q && !out_ready;
        upd_z   = 1'b0;
        sh_load = 1'b0;
        sh_step = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        acc_nx  = acc_q + (mplr_q[0] ? mcand_q : '0);
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        mcnt_d  = mcnt_q;
`endif
        if (accept) begin
            ov_d  = 1'b1;
            wb_d  = 1'b1;
            ill_d = 1'b0;
            upd_z = 1'b1;
            case (op)
                OP_AND:  res_d = a & b;
                OP_OR:   res_d = a | b;
                OP_XOR:  res_d = a ^ b;
                OP_ADD, OP_ADDC: begin
                    res_d         = sum[WIDTH-1:0];
                    flg_d[FLAG_C] = sum[WIDTH];
                    flg_d[FLAG_F] = ovf_add;
                    flg_d[FLAG_N] = sum[WIDTH-1];
                end
                OP_SUB: begin
                    res_d         = diff[WIDTH-1:0];
                    flg_d[FLAG_C] = diff[WIDTH];
                    flg_d[FLAG_F] = ovf_sub;
                    flg_d[FLAG_N] = diff[WIDTH-1];
                end
                OP_CMP: begin
                    res_d         = diff[WIDTH-1:0];
                    wb_d          = 1'b0;
                    upd_z         = 1'b0;
                    flg_d[FLAG_L] = diff[WIDTH];
                    flg_d[FLAG_Z] = a == b;
                    flg_d[FLAG_N] = diff[WIDTH-1] ^ ovf_sub;
                    flg_d[FLAG_F] = ovf_sub;
                end
                OP_MOV: begin
                    res_d         = a;
                    flg_d[FLAG_N] = a[WIDTH-1];
                end
                OP_LSH, OP_ASHU: begin
                    sh_load = 1'b1;
                    upd_z   = sh_zero;
                    res_d   = sh_zero ? a : res_q;
                    ov_d    = sh_zero;
                    state_d = sh_zero ? S_IDLE : S_SHIFT;
                end
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    acc_d   = '0;
                    mcand_d = {{WIDTH{1'b0}}, a};
                    mplr_d  = b;
                    mcnt_d  = CW'(WIDTH);
                    upd_z   = 1'b0;
                    ov_d    = 1'b0;
                    state_d = S_MUL;
                end
`endif
                default: begin
                    res_d = '0;
                    wb_d  = 1'b0;
                    ill_d = 1'b1;
                    upd_z = 1'b0;
                end
            endcase
        end else if (state_q == S_SHIFT) begin
            sh_step = 1'b1;
            if (sh_last) begin
                res_d   = sh_next;
                upd_z   = 1'b1;
                ov_d    = 1'b1;
                state_d = S_IDLE;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state_q == S_MUL) begin
            acc_d   = acc_nx;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            mcnt_d  = mcnt_q - CW'(1);
            if (mcnt_q == CW'(1)) begin
                res_d         = acc_nx[WIDTH-1:0];
                flg_d[FLAG_C] = |acc_nx[2*WIDTH-1:WIDTH];
                upd_z         = 1'b1;
                ov_d          = 1'b1;
                state_d       = S_IDLE;
            end
        end
`endif
        if (upd_z) flg_d[FLAG_Z] = res_d == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            wb_q    <= 1'b0;
            ill_q   <= 1'b0;
            ov_q    <= 1'b0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            wb_q    <= wb_d;
            ill_q   <= ill_d;
            ov_q    <= ov_d;
            flg_q   <= flg_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            mcnt_q  <= mcnt_d;
        end
    end
`endif

    assign out_valid   = ov_q;
    assign result      = res_q;
    assign out_wb      = wb_q;
    assign out_illegal = ill_q;
    assign flags       = flg_q;
endmodule
